rotl_seq_ctrl: RTL and testbench
================================

// Module: rotl_seq_ctrl
// PURPOSE
//  Sequencing controller for a multi-cycle 256-bit rotate-left. It accepts one
//  operand+shift via valid/ready, rotates one log2 barrel stage per enabled cycle
//  on a registered datapath, and presents the result via valid/ready.
//  It is the timing-closed replacement for a single-cycle wide shifter. Unlike a
//  plain '<<', it wraps bits around (true rotate).
// PARAMETERS
//  DATA_WIDTH  256                   operand width; must be a power of two, >= 2
//  SHAMT_W     $clog2(DATA_WIDTH)=8  shift-amount width = number of barrel stages
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  enable     in   1           global stall; 0 freezes all state and outputs
//  in_valid   in   1           request present
//  in_ready   out  1           controller can accept (state==IDLE && enable)
//  a_in       in   DATA_WIDTH  operand, sampled on in_valid&&in_ready
//  shift_in   in   SHAMT_W     rotate amount, modulo DATA_WIDTH by construction
//  out_valid  out  1           a_out holds a finished result
//  out_ready  in   1           consumer takes result
//  a_out      out  DATA_WIDTH  rotated result (registered data reg)
//  busy       out  1           state!=IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, data_q=0, shamt_q=0, stage_q=0.
//   Outputs: a_out=0, out_valid=0, busy=0; in_ready=enable.
//  FSM: IDLE -> ROTATE -> DONE -> IDLE. No transition or register update
//   occurs on any cycle with enable=0.
//  IDLE: on in_valid&&in_ready, load data_q<=a_in, shamt_q<=shift_in, stage_q<=0,
//   then go to ROTATE. in_valid without in_ready is ignored; the requester holds it.
//  ROTATE: each enabled cycle, if shamt_q[stage_q] then data_q<=rotl(data_q, 2**stage_q);
//   stage_q<=stage_q+1. After stage SHAMT_W-1 completes, go to DONE.
//  Fixed latency: every stage executes, even for shamt bits =0 and shift=0.
//   Accept at edge T0 -> out_valid=1 after edge T0+SHAMT_W (8 enabled cycles).
//  DONE: out_valid=1, a_out=data_q, held stable until out_ready. Transfer edge -> IDLE,
//   out_valid=0. in_ready stays 0 during the transfer cycle, so there is no same-cycle
//   re-accept. Throughput: 1 op per SHAMT_W+2 enabled cycles.
//  rotl(x,k) = (x<<k)|(x>>(DATA_WIDTH-k)), computed in DATA_WIDTH bits, no widening.
//  enable=0 in DONE with out_ready=1: no transfer; out_valid stays 1.
//  Async reset mid-ROTATE/DONE: the op is dropped and all values return to reset
//   values. in_ready=1 on the first enabled cycle after release.
//  stage_q is SHAMT_W bits wide. Its wrap after the last stage is unused; the FSM
//   exits on stage_q==SHAMT_W-1.
// STRUCTURE
//  Package rotl_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_ROTATE=2'd1, ST_DONE=2'd2
//   - SHAMT_W derivation
//  Sub-module rotl_stage (combinational): rotates DATA_WIDTH bits left by
//   2**stage when en=1. Instantiated once; its output feeds data_q.
//  Top: FSM, data_q/shamt_q/stage_q registers, handshake logic.
// TESTING
//  1 a_in=256'h1, shift=1, out_ready=1 -> a_out=256'h2, out_valid 8 cycles after accept.
//  2 wrap: a_in=1<<255, shift=1 -> a_out=256'h1; a_in=256'h3, shift=255 -> a_out={1'b1,253'b0,2'b01}.
//  3 shift=0, a_in=random -> a_out=a_in with full 8-cycle latency; shift=128 swaps halves.
//  4 backpressure: out_ready=0 for 5 cycles in DONE -> a_out/out_valid stable, in_ready=0;
//    a second request held on in_valid is accepted only after the transfer.
//  5 enable=0 for 3 cycles mid-ROTATE -> latency grows by exactly 3; result unchanged.
//  6 rst_n low at stage 4 -> out_valid=0, a_out=0, busy=0 immediately; a new op completes correctly.

Source files
------------

// File: rtl/rotl_pkg.sv
// Shared definitions for the rotate-left sequencing controller.
//   DATA_WIDTH : operand width (power of two, >= 2)
//   SHAMT_W    : shift-amount width, which is also the number of barrel stages
//   state_t    : controller state encoding
//   rotl()     : true rotate-left within DATA_WIDTH bits
package rotl_pkg;

    localparam int DATA_WIDTH = 256;
    localparam int SHAMT_W    = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // k == 0 yields x because x >> DATA_WIDTH is zero.
    function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] x,
                                                   input int unsigned          k);
        rotl = (x << k) | (x >> (DATA_WIDTH - k));
    endfunction

endpackage

// File: rtl/rotl_seq_ctrl_if.sv
// Request/response bundle for rotl_seq_ctrl.
//   enable    : global stall, 0 freezes the controller
//   in_valid / in_ready / a_in / shift_in : operand handshake
//   out_valid / out_ready / a_out         : result handshake
//   busy      : controller is not idle
// master = requester/consumer side, slave = controller side.
interface rotl_seq_ctrl_if;
    import rotl_pkg::*;

    logic                  enable;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a_in;
    logic [SHAMT_W-1:0]    shift_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] a_out;
    logic                  busy;

    modport master (
        output enable, in_valid, a_in, shift_in, out_ready,
        input  in_ready, out_valid, a_out, busy
    );

    modport slave (
        input  enable, in_valid, a_in, shift_in, out_ready,
        output in_ready, out_valid, a_out, busy
    );

endinterface

// File: rtl/rotl_stage.sv
// One barrel stage: rotates data_in left by 2**stage when en=1, else passes it.
//   data_in  : operand
//   stage    : barrel stage index (0 .. SHAMT_W-1)
//   en       : apply this stage's rotation
//   data_out : result (combinational)
module rotl_stage
    import rotl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [SHAMT_W-1:0]    stage,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] data_out
);

    assign data_out = en ? rotl(data_in, 32'd1 << stage) : data_in;

endmodule

// File: rtl/rotl_seq_ctrl.sv
// Multi-cycle DATA_WIDTH-bit rotate-left controller. One barrel stage is
// applied per enabled cycle to a registered datapath, giving a fixed latency
// of SHAMT_W enabled cycles from accept to result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rotl_seq_ctrl_if.slave (enable, operand and result handshakes, busy)
module rotl_seq_ctrl
    import rotl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    rotl_seq_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(SHAMT_W);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rot_d;
    logic [SHAMT_W-1:0]    shamt_q;
    logic [SHAMT_W-1:0]    stage_q;
    logic                  accept;
    logic                  last_stage;

    assign bus.in_ready  = (state_q == ST_IDLE) && bus.enable;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.a_out     = data_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_stage = (stage_q == SHAMT_W'(SHAMT_W - 1));

    rotl_stage u_stage (
        .data_in  (data_q),
        .stage    (stage_q),
        .en       (shamt_q[stage_q[IDX_W-1:0]]),
        .data_out (rot_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)        state_d = ST_ROTATE;
            ST_ROTATE: if (last_stage)    state_d = ST_DONE;
            ST_DONE:   if (bus.out_ready) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Every register, including the FSM, holds while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            stage_q <= '0;
        end else if (bus.enable) begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q  <= bus.a_in;
                        shamt_q <= bus.shift_in;
                        stage_q <= '0;
                    end
                end
                ST_ROTATE: begin
                    // Stage runs even when its shamt bit is 0: fixed latency.
                    data_q  <= rot_d;
                    stage_q <= stage_q + SHAMT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rotl_seq_ctrl.sv
module tb_rotl_seq_ctrl;
    import rotl_pkg::*;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef struct {
        word_t d;
        int    lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rotl_seq_ctrl_if bus();

    rotl_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc   = 0;
    bit   seen  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, data on each transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) acc = cyc + 1;
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got out_valid with empty scoreboard");
                end else begin
                    chk("latency", word_t'(cyc - acc), word_t'(sb[0].lat));
                end
            end
            if (bus.out_valid && bus.out_ready && bus.enable) begin
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("a_out", bus.a_out, e.d);
                end
                seen = 1'b0;
            end
        end
    end

    task automatic drive_req(input word_t a, input logic [SHAMT_W-1:0] sh);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.shift_in = sh;
    endtask

    task automatic send(input word_t a, input logic [SHAMT_W-1:0] sh,
                        input word_t exp, input int lat);
        exp_t e;
        e.d = exp;
        e.lat = lat;
        sb.push_back(e);
        drive_req(a, sh);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (!bus.in_ready) chk("accept_wait", word_t'(bus.in_ready), word_t'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", word_t'(sb.size()), word_t'(0));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("out_valid_wait", word_t'(bus.out_valid), word_t'(1));
    endtask

    word_t one, top, va, vb, vh, vl, hold_a;
    exp_t  eb;

    initial begin
        one = word_t'(1);
        top = one << 255;
        va  = 256'hdeadbeef_01234567_89abcdef_cafef00d_13579bdf_2468ace0_0badc0de_feedface;
        vh  = 256'h01234567_89abcdef_fedcba98_76543210_00000000_00000000_00000000_00000000;
        vl  = 256'h00000000_00000000_00000000_00000000_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        vb  = vh | vl;

        bus.enable    = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.shift_in  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", word_t'(bus.out_valid), word_t'(0));
        chk("rst_a_out", bus.a_out, word_t'(0));
        chk("rst_busy", word_t'(bus.busy), word_t'(0));
        chk("rst_in_ready", word_t'(bus.in_ready), word_t'(1));
        bus.enable = 1'b0;
        #1;
        chk("rst_in_ready_dis", word_t'(bus.in_ready), word_t'(0));
        bus.enable = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic and wrap-around rotates
        send(one, 8'd1, word_t'(2), 8);
        wait_done();
        send(top, 8'd1, one, 8);
        wait_done();
        send(word_t'(3), 8'd255, top | one, 8);
        wait_done();
        send(one, 8'd5, word_t'(32'h20), 8);
        wait_done();
        send(one << 200, 8'd131, one << 75, 8);
        wait_done();

        // Zero shift keeps full latency; 128 swaps halves
        send(va, 8'd0, va, 8);
        wait_done();
        send(vb, 8'd128, (vl << 128) | (vh >> 128), 8);
        wait_done();

        // Backpressure with a second request held
        bus.out_ready = 1'b0;
        send(va, 8'd4, {va[251:0], va[255:252]}, 8);
        wait_valid();
        hold_a = bus.a_out;
        eb.d = {vb[254:0], vb[255]};
        eb.lat = 8;
        sb.push_back(eb);
        drive_req(vb, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", word_t'(bus.out_valid), word_t'(1));
            chk("bp_a_out", bus.a_out, hold_a);
            chk("bp_in_ready", word_t'(bus.in_ready), word_t'(0));
            chk("bp_busy", word_t'(bus.busy), word_t'(1));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("xfer_in_ready", word_t'(bus.in_ready), word_t'(0));
        @(negedge clk);
        chk("post_xfer_out_valid", word_t'(bus.out_valid), word_t'(0));
        chk("post_xfer_in_ready", word_t'(bus.in_ready), word_t'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done();

        // Stall of 3 cycles mid-rotate
        send(va, 8'd77, {va[178:0], va[255:179]}, 11);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.enable = 1'b1;
        wait_done();

        // Disabled in DONE with out_ready high: no transfer
        bus.out_ready = 1'b0;
        send(one, 8'd2, word_t'(4), 8);
        wait_valid();
        @(posedge clk); #1;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("dis_out_valid", word_t'(bus.out_valid), word_t'(1));
            chk("dis_in_ready", word_t'(bus.in_ready), word_t'(0));
        end
        @(posedge clk); #1;
        bus.enable = 1'b1;
        wait_done();

        // Async reset at stage 4
        send(va, 8'd3, {va[252:0], va[255:253]}, 8);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", word_t'(bus.out_valid), word_t'(0));
        chk("mid_rst_a_out", bus.a_out, word_t'(0));
        chk("mid_rst_busy", word_t'(bus.busy), word_t'(0));
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", word_t'(bus.in_ready), word_t'(1));
        send(vb, 8'd16, {vb[239:0], vb[255:240]}, 8);
        wait_done();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
